// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constant control patterns for the pipeline hazard controller.
package hazard_ctrl_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic {
        CTRL_RUN     = 1'b0,
        CTRL_MD_BUSY = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_bubble;
        logic md_start;
    } pipe_ctrl_t;

    // Normal flow: every stage advances, nothing is squashed.
    localparam pipe_ctrl_t CTRL_PASS = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                         if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                         ex_mem_bubble: 1'b0, md_start: 1'b0};
    // EX is occupied by a mul/div: hold the front end and feed NOPs into MEM.
    localparam pipe_ctrl_t CTRL_MD_FREEZE = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0,
                                              if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                              ex_mem_bubble: 1'b1, md_start: 1'b0};
    localparam pipe_ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                           if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                           ex_mem_bubble: 1'b0, md_start: 1'b0};
    localparam pipe_ctrl_t CTRL_LOAD_USE = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1,
                                             if_id_flush: 1'b0, id_ex_flush: 1'b1,
                                             ex_mem_bubble: 1'b0, md_start: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: default assignment first, so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: flops use non-blocking assignments so all state updates together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// mul/div occupancy of EX with a start/done handshake and watchdog.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int CNT_W      = 32,
    parameter int MD_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_is_md,
    input  logic              ex_br_taken,
    input  logic              md_done,
    output logic              md_start,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_bubble,
    output logic              md_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int WD_W = $clog2(MD_TIMEOUT + 1);

    ctrl_state_e state_q, state_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic md_err_q, md_err_d;
    pipe_ctrl_t ctrl;
    logic load_use;
    logic wd_fire;
    logic br_flush;

    assign load_use = ex_is_load && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        ctrl     = CTRL_PASS;
        state_d  = state_q;
        wd_cnt_d = wd_cnt_q;
        md_err_d = md_err_q;
        wd_fire  = 1'b0;
        br_flush = 1'b0;
        unique case (state_q)
            CTRL_RUN: begin
                if (ex_is_md) begin
                    ctrl          = CTRL_MD_FREEZE;
                    ctrl.md_start = 1'b1;
                    state_d       = CTRL_MD_BUSY;
                    wd_cnt_d      = WD_W'(1);
                end else if (ex_br_taken) begin
                    ctrl     = CTRL_BRANCH;
                    br_flush = 1'b1;
                end else if (load_use) begin
                    ctrl = CTRL_LOAD_USE;
                end
            end
            CTRL_MD_BUSY: begin
                if (md_done) begin
                    state_d = CTRL_RUN;
                end else if (wd_cnt_q == WD_W'(MD_TIMEOUT)) begin
                    // Give up on the unit: release the md instruction as if it finished.
                    wd_fire  = 1'b1;
                    md_err_d = 1'b1;
                    state_d  = CTRL_RUN;
                end else begin
                    ctrl     = CTRL_MD_FREEZE;
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            default: state_d = CTRL_RUN;
        endcase
        // Outputs are pinned to pass-through while reset is held, whatever the inputs do.
        if (!rst_n) begin
            ctrl     = CTRL_PASS;
            br_flush = 1'b0;
            wd_fire  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CTRL_RUN;
            wd_cnt_q <= '0;
            md_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wd_cnt_q <= wd_cnt_d;
            md_err_q <= md_err_d;
        end
    end

    assign pc_en         = ctrl.pc_en;
    assign if_id_en      = ctrl.if_id_en;
    assign id_ex_en      = ctrl.id_ex_en;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign ex_mem_bubble = ctrl.ex_mem_bubble;
    assign md_start      = ctrl.md_start;
    assign md_err        = rst_n & (md_err_q | wd_fire);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~ctrl.pc_en),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (br_flush),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int REG_AW     = 5;
    localparam int CNT_W      = 3;
    localparam int MD_TIMEOUT = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    // {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble, md_start}
    localparam logic [6:0] EXP_PASS     = 7'b1110000;
    localparam logic [6:0] EXP_FREEZE   = 7'b0000010;
    localparam logic [6:0] EXP_MD_START = 7'b0000011;
    localparam logic [6:0] EXP_BRANCH   = 7'b1111100;
    localparam logic [6:0] EXP_LOAD_USE = 7'b0010100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [REG_AW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_use_rs1 = 0, id_use_rs2 = 0, ex_is_load = 0, ex_is_md = 0, ex_br_taken = 0, md_done = 0;
    logic md_start, pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble, md_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W), .MD_TIMEOUT(MD_TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .ex_rd         (ex_rd),
        .ex_is_load    (ex_is_load),
        .ex_is_md      (ex_is_md),
        .ex_br_taken   (ex_br_taken),
        .md_done       (md_done),
        .md_start      (md_start),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .id_ex_en      (id_ex_en),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_bubble (ex_mem_bubble),
        .md_err        (md_err),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: is a mul/div occupying EX, how long has it been there,
    // has the watchdog ever fired, and the two event tallies.
    bit m_busy = 0;
    int m_age  = 0;
    bit m_err  = 0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [6:0] ctrl_vec();
        return {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble, md_start};
    endfunction

    task automatic set_idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0;
        ex_is_load = 0; ex_is_md = 0; ex_br_taken = 0; md_done = 0;
    endtask

    task automatic rand_inputs();
        id_rs1      = REG_AW'($urandom_range(0, 7));
        id_rs2      = REG_AW'($urandom_range(0, 7));
        ex_rd       = REG_AW'($urandom_range(0, 7));
        id_use_rs1  = 1'($urandom_range(0, 1));
        id_use_rs2  = 1'($urandom_range(0, 1));
        ex_is_load  = 1'($urandom_range(0, 1));
        ex_is_md    = ($urandom_range(0, 7) == 0);
        ex_br_taken = ($urandom_range(0, 3) == 0);
        md_done     = ($urandom_range(0, 3) == 0);
    endtask

    // Called just after a rising edge with inputs already applied; checks this
    // cycle's outputs at the falling edge, then advances the model at the next edge.
    task automatic cycle();
        logic [6:0] exp_ctrl;
        bit lu, fire, flush_now, nxt_busy;
        int nxt_age;
        @(negedge clk);
        lu = ex_is_load && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        exp_ctrl = EXP_PASS; fire = 0; flush_now = 0;
        nxt_busy = m_busy; nxt_age = m_age;
        if (m_busy) begin
            if (md_done) nxt_busy = 0;
            else if (m_age >= MD_TIMEOUT) begin fire = 1; nxt_busy = 0; end
            else begin exp_ctrl = EXP_FREEZE; nxt_age = m_age + 1; end
        end else if (ex_is_md) begin
            exp_ctrl = EXP_MD_START; nxt_busy = 1; nxt_age = 1;
        end else if (ex_br_taken) begin
            exp_ctrl = EXP_BRANCH; flush_now = 1;
        end else if (lu) begin
            exp_ctrl = EXP_LOAD_USE;
        end
        check("ctrl", 64'(ctrl_vec()), 64'(exp_ctrl));
        check("md_err", 64'(md_err), 64'(m_err | fire));
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
        @(posedge clk);
        m_busy = nxt_busy;
        m_age  = nxt_age;
        m_err  = m_err | fire;
        if (!exp_ctrl[6]) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
        if (flush_now)    m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
        #1;
    endtask

    // Entered just after a rising edge; leaves just after a rising edge with reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        m_busy = 0; m_age = 0; m_err = 0; m_stall = 0; m_flush = 0;
        rand_inputs();
        #2;
        check("rst_ctrl", 64'(ctrl_vec()), 64'(EXP_PASS));
        check("rst_md_err", 64'(md_err), 64'(0));
        check("rst_stall", 64'(stall_cnt), 64'(0));
        check("rst_flush", 64'(flush_cnt), 64'(0));
        @(posedge clk);
        #3;
        ex_is_md = 1'b1; ex_br_taken = 1'b0;
        #1;
        check("rst_ctrl_md", 64'(ctrl_vec()), 64'(EXP_PASS));
        rst_n = 1'b1;
        set_idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Load-use on rs2, then the bubble in EX lets ID proceed.
        ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        cycle();
        set_idle(); id_rs2 = 5; id_use_rs2 = 1;
        cycle();
        check("lu_stall_cnt", 64'(stall_cnt), 64'(1));

        // x0 destination and an operand that is not actually read.
        set_idle(); ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        cycle();
        set_idle(); ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0;
        cycle();

        // Taken branch masks a simultaneous load-use.
        set_idle(); ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; ex_br_taken = 1;
        cycle();
        set_idle();
        cycle();
        check("br_flush_cnt", 64'(flush_cnt), 64'(1));
        check("br_stall_cnt", 64'(stall_cnt), 64'(1));

        // Mul/div finishing in its 3rd busy cycle.
        set_idle(); ex_is_md = 1;
        cycle();
        for (int i = 1; i <= 3; i++) begin
            md_done = (i == 3);
            cycle();
        end
        set_idle();
        cycle();
        check("md_stall_cnt", 64'(stall_cnt), 64'(4));

        // Mul/div that never finishes: watchdog fires in busy cycle MD_TIMEOUT.
        set_idle(); ex_is_md = 1;
        cycle();
        for (int i = 1; i <= MD_TIMEOUT; i++) cycle();
        set_idle();
        cycle();
        check("wd_md_err", 64'(md_err), 64'(1));
        check("wd_stall_sat", 64'(stall_cnt), 64'(CNT_MAX));

        // Reset in the middle of a mul/div aborts it without reissuing md_start.
        set_idle(); ex_is_md = 1;
        cycle();
        cycle();
        do_reset();
        cycle();

        // Counter saturation with nine separate load-use stalls.
        for (int i = 0; i < 9; i++) begin
            set_idle(); ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
            cycle();
            set_idle();
            cycle();
        end
        check("sat_stall_cnt", 64'(stall_cnt), 64'(CNT_MAX));

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                rand_inputs();
                cycle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
